reg_rename_file: RTL

Architectural register file with per-register rename tags. It is the commit-side partner of the reorder buffer.
- Decode allocates a ROB id to the destination register.
- Decode reads operand value/tag pairs combinationally.
- The ROB retires results into it and clears the tags.
- A rollback flushes all tags and leaves the committed architectural values in place.

---
 rtl/reg_rename_file_pkg.sv | 20 ++
 rtl/rf_read_port.sv | 44 ++++
 rtl/reg_rename_file.sv | 106 ++++++++++
 3 files changed

// File: rtl/reg_rename_file_pkg.sv
// Shared widths, constants and storage types for the
// architectural register file with rename tags.
package reg_rename_file_pkg;

  localparam int REG_NUM   = 32;
  localparam int REG_IDX_W = 5;
  localparam int DATA_W    = 32;
  localparam int ROB_IDX_W = 4;
  localparam int CNT_W     = 32;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic [REG_IDX_W-1:0] ZERO_REG = '0;

  typedef logic [REG_NUM-1:0][DATA_W-1:0]    value_arr_t;
  typedef logic [REG_NUM-1:0][ROB_IDX_W-1:0] tag_arr_t;
  typedef logic [REG_NUM-1:0]                busy_vec_t;

endpackage

// File: rtl/rf_read_port.sv
// One operand read port: table lookup plus same-cycle commit bypass.
// In: idx_i, stored busy/tag/value arrays, commit bus, rdy_i.
// Out: busy_o, tag_o, value_o (combinational).
module rf_read_port
  import reg_rename_file_pkg::*;
(
  input  logic [REG_IDX_W-1:0] idx_i,
  input  busy_vec_t            busy_i,
  input  tag_arr_t             tag_i,
  input  value_arr_t           value_i,
  input  logic                 rdy_i,
  input  logic                 commit_valid_i,
  input  logic [REG_IDX_W-1:0] commit_rd_i,
  input  logic [ROB_IDX_W-1:0] commit_rob_id_i,
  input  logic [DATA_W-1:0]    commit_value_i,
  output logic                 busy_o,
  output logic [ROB_IDX_W-1:0] tag_o,
  output logic [DATA_W-1:0]    value_o
);

  logic hit;

  // Only the producer we are waiting on may forward its result.
  assign hit = commit_valid_i && rdy_i
            && (idx_i != ZERO_REG)
            && (commit_rd_i == idx_i)
            && busy_i[idx_i]
            && (tag_i[idx_i] == commit_rob_id_i);

  always_comb begin
    busy_o  = busy_i[idx_i];
    tag_o   = tag_i[idx_i];
    value_o = value_i[idx_i];
    if (idx_i == ZERO_REG) begin
      busy_o  = FALSE;
      tag_o   = '0;
      value_o = '0;
    end else if (hit) begin
      busy_o  = FALSE;
      value_o = commit_value_i;
    end
  end

endmodule

// File: rtl/reg_rename_file.sv
// Architectural register file with per-register rename tags.
// Ports: alloc (decode), commit (ROB), roll_back, two read ports, retire_cnt.
module reg_rename_file
  import reg_rename_file_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 alloc_valid,
  input  logic [REG_IDX_W-1:0] alloc_rd,
  input  logic [ROB_IDX_W-1:0] alloc_rob_id,
  input  logic                 commit_valid,
  input  logic [REG_IDX_W-1:0] commit_rd,
  input  logic [ROB_IDX_W-1:0] commit_rob_id,
  input  logic [DATA_W-1:0]    commit_value,
  input  logic                 roll_back,
  input  logic [REG_IDX_W-1:0] rs1_idx,
  output logic                 rs1_busy,
  output logic [ROB_IDX_W-1:0] rs1_tag,
  output logic [DATA_W-1:0]    rs1_value,
  input  logic [REG_IDX_W-1:0] rs2_idx,
  output logic                 rs2_busy,
  output logic [ROB_IDX_W-1:0] rs2_tag,
  output logic [DATA_W-1:0]    rs2_value,
  output logic [CNT_W-1:0]     retire_cnt
);

  value_arr_t       value_q, value_d;
  tag_arr_t         tag_q, tag_d;
  busy_vec_t        busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    value_d = value_q;
    tag_d   = tag_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    if (rdy) begin
      if (commit_valid) begin
        cnt_d = cnt_q + 1'b1;
        if (commit_rd != ZERO_REG) begin
          value_d[commit_rd] = commit_value;
          // A tag mismatch means a younger producer owns rd.
          if (busy_q[commit_rd]
              && (tag_q[commit_rd] == commit_rob_id)) begin
            busy_d[commit_rd] = FALSE;
          end
        end
      end
      // Alloc is applied after commit so it wins on the same rd.
      if (roll_back) begin
        busy_d = '0;
      end else if (alloc_valid && (alloc_rd != ZERO_REG)) begin
        busy_d[alloc_rd] = TRUE;
        tag_d[alloc_rd]  = alloc_rob_id;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= '0;
      tag_q   <= '0;
      busy_q  <= '0;
      cnt_q   <= '0;
    end else begin
      value_q <= value_d;
      tag_q   <= tag_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  assign retire_cnt = cnt_q;

  rf_read_port u_rs1 (
    .idx_i           (rs1_idx),
    .busy_i          (busy_q),
    .tag_i           (tag_q),
    .value_i         (value_q),
    .rdy_i           (rdy),
    .commit_valid_i  (commit_valid),
    .commit_rd_i     (commit_rd),
    .commit_rob_id_i (commit_rob_id),
    .commit_value_i  (commit_value),
    .busy_o          (rs1_busy),
    .tag_o           (rs1_tag),
    .value_o         (rs1_value)
  );

  rf_read_port u_rs2 (
    .idx_i           (rs2_idx),
    .busy_i          (busy_q),
    .tag_i           (tag_q),
    .value_i         (value_q),
    .rdy_i           (rdy),
    .commit_valid_i  (commit_valid),
    .commit_rd_i     (commit_rd),
    .commit_rob_id_i (commit_rob_id),
    .commit_value_i  (commit_value),
    .busy_o          (rs2_busy),
    .tag_o           (rs2_tag),
    .value_o         (rs2_value)
  );

endmodule
